// File: rtl/bw_test_sequencer_if.sv
// Sequencer <-> AXI4 bandwidth tester handshake: start pulses out, done pulses and times back.
interface bw_test_sequencer_if;
    logic        start_write;
    logic        start_read;
    logic        wr_done;
    logic        rd_done;
    logic [31:0] wr_time;
    logic [31:0] rd_time;

    modport master (
        output start_write, start_read,
        input  wr_done, rd_done, wr_time, rd_time
    );

    modport slave (
        input  start_write, start_read,
        output wr_done, rd_done, wr_time, rd_time
    );
endinterface

// File: rtl/bw_test_sequencer.sv
// Multi-iteration run controller for the AXI4 bandwidth tester; gathers min/max/sum
// of reported write and read times per run.
module bw_test_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 200000000,
    parameter int unsigned ITER_W         = 16
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  cmd_start_i,
    input  logic                  cmd_abort_i,
    input  logic [1:0]            cfg_mode_i,
    input  logic [ITER_W-1:0]     cfg_iterations_i,
    bw_test_sequencer_if.master   tst,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_timeout_o,
    output logic [ITER_W-1:0]     iter_count_o,
    output logic [31:0]           wr_min_o,
    output logic [31:0]           wr_max_o,
    output logic [31:0]           rd_min_o,
    output logic [31:0]           rd_max_o,
    output logic [31+ITER_W:0]    wr_sum_o,
    output logic [31+ITER_W:0]    rd_sum_o
);
    localparam int unsigned SUM_W = 32 + ITER_W;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] M_WR    = 2'd0;
    localparam logic [1:0] M_RD    = 2'd1;
    localparam logic [1:0] M_WR_RD = 2'd2;
    localparam logic [1:0] M_CONC  = 2'd3;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, NEXT, FINISH} state_t;

    state_t              state_q;
    logic [1:0]          mode_q;
    logic [ITER_W-1:0]   iters_q, iter_q;
    logic [TMO_W-1:0]    tmo_q;
    logic                wr_seen_q, rd_seen_q, rd_phase_q;
    logic                start_write_q, start_read_q;
    logic                busy_q, done_q, err_q;
    logic [31:0]         wr_min_q, wr_max_q, rd_min_q, rd_max_q;
    logic [SUM_W-1:0]    wr_sum_q, rd_sum_q;

    logic                wr_acc, rd_acc, phase_done, tmo_hit;
    logic [TMO_W-1:0]    tmo_d;
    logic [31:0]         wr_min_d, wr_max_d, rd_min_d, rd_max_d;

    // Which done pulses the current phase is still waiting for
    always_comb begin
        wr_acc     = 1'b0;
        rd_acc     = 1'b0;
        phase_done = 1'b0;
        if (state_q == WAIT) begin
            unique case (mode_q)
                M_WR:    wr_acc = tst.wr_done;
                M_RD:    rd_acc = tst.rd_done;
                M_WR_RD: begin
                    wr_acc = tst.wr_done && !rd_phase_q;
                    rd_acc = tst.rd_done &&  rd_phase_q;
                end
                default: begin
                    wr_acc = tst.wr_done && !wr_seen_q;
                    rd_acc = tst.rd_done && !rd_seen_q;
                end
            endcase
            unique case (mode_q)
                M_WR:    phase_done = wr_acc;
                M_RD,
                M_WR_RD: phase_done = rd_acc;
                default: phase_done = (wr_seen_q || wr_acc) && (rd_seen_q || rd_acc);
            endcase
        end
        tmo_d    = tmo_q + TMO_W'(1);
        tmo_hit  = (tmo_d == TMO_W'(TIMEOUT_CYCLES));
        wr_min_d = (tst.wr_time < wr_min_q) ? tst.wr_time : wr_min_q;
        wr_max_d = (tst.wr_time > wr_max_q) ? tst.wr_time : wr_max_q;
        rd_min_d = (tst.rd_time < rd_min_q) ? tst.rd_time : rd_min_q;
        rd_max_d = (tst.rd_time > rd_max_q) ? tst.rd_time : rd_max_q;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            mode_q        <= M_WR;
            iters_q       <= ITER_W'(1);
            iter_q        <= '0;
            tmo_q         <= '0;
            wr_seen_q     <= 1'b0;
            rd_seen_q     <= 1'b0;
            rd_phase_q    <= 1'b0;
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            wr_min_q      <= '1;
            wr_max_q      <= '0;
            rd_min_q      <= '1;
            rd_max_q      <= '0;
            wr_sum_q      <= '0;
            rd_sum_q      <= '0;
        end else begin
            start_write_q <= 1'b0;
            start_read_q  <= 1'b0;
            // Abort wins over any done pulse or timeout arriving in the same cycle
            if (cmd_abort_i && (state_q != IDLE)) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: if (cmd_start_i) begin
                        mode_q   <= cfg_mode_i;
                        iters_q  <= (cfg_iterations_i == '0) ? ITER_W'(1) : cfg_iterations_i;
                        done_q   <= 1'b0;
                        err_q    <= 1'b0;
                        iter_q   <= '0;
                        wr_min_q <= '1;
                        wr_max_q <= '0;
                        rd_min_q <= '1;
                        rd_max_q <= '0;
                        wr_sum_q <= '0;
                        rd_sum_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= ISSUE;
                    end
                    ISSUE: begin
                        start_write_q <= (mode_q != M_RD);
                        start_read_q  <= (mode_q == M_RD) || (mode_q == M_CONC);
                        tmo_q         <= '0;
                        wr_seen_q     <= 1'b0;
                        rd_seen_q     <= 1'b0;
                        rd_phase_q    <= 1'b0;
                        state_q       <= WAIT;
                    end
                    WAIT: begin
                        tmo_q <= tmo_d;
                        if (wr_acc) begin
                            wr_seen_q <= 1'b1;
                            wr_min_q  <= wr_min_d;
                            wr_max_q  <= wr_max_d;
                            wr_sum_q  <= wr_sum_q + SUM_W'(tst.wr_time);
                        end
                        if (rd_acc) begin
                            rd_seen_q <= 1'b1;
                            rd_min_q  <= rd_min_d;
                            rd_max_q  <= rd_max_d;
                            rd_sum_q  <= rd_sum_q + SUM_W'(tst.rd_time);
                        end
                        // Write-then-read: read phase is issued the cycle after wr_done
                        if ((mode_q == M_WR_RD) && wr_acc) begin
                            rd_phase_q   <= 1'b1;
                            start_read_q <= 1'b1;
                            tmo_q        <= '0;
                        end
                        if (phase_done) begin
                            iter_q  <= iter_q + ITER_W'(1);
                            state_q <= NEXT;
                        end else if (tmo_hit && !((mode_q == M_WR_RD) && wr_acc)) begin
                            err_q   <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                    NEXT:    state_q <= (iter_q == iters_q) ? FINISH : ISSUE;
                    FINISH: begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign tst.start_write = start_write_q;
    assign tst.start_read  = start_read_q;
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign error_timeout_o = err_q;
    assign iter_count_o    = iter_q;
    assign wr_min_o        = wr_min_q;
    assign wr_max_o        = wr_max_q;
    assign rd_min_o        = rd_min_q;
    assign rd_max_o        = rd_max_q;
    assign wr_sum_o        = wr_sum_q;
    assign rd_sum_o        = rd_sum_q;
endmodule
